// File: rtl/seq_programmer.sv
// rtl/seq_programmer.sv - captures a double-entered button code for seq_detecter.
// Optional idle abort timer enabled by defining SEQ_PROG_TIMEOUT_EN.
module seq_programmer #(
  parameter int                   SEQ_LEN      = 4,
  parameter logic [2*SEQ_LEN-1:0] DEFAULT_CODE = (2*SEQ_LEN)'(8'h1B),
  parameter int                   TIMEOUT_CYC  = 600000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 prog,
  input  logic                 b1,
  input  logic                 b2,
  input  logic                 b3,
  input  logic                 check,
  output logic [2*SEQ_LEN-1:0] code,
  output logic                 code_upd,
  output logic                 error,
  output logic                 busy,
  output logic [1:0]           state_check
);

  localparam int            CW  = $clog2(SEQ_LEN + 1);
  localparam logic [CW-1:0] LEN = CW'(SEQ_LEN);

  if (SEQ_LEN < 2 || SEQ_LEN > 8) begin : g_bad_len
    $error("seq_programmer: SEQ_LEN must be 2..8");
  end
  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("seq_programmer: TIMEOUT_CYC must be at least 2");
  end

  typedef enum logic [1:0] {IDLE = 2'b00, ENTER1 = 2'b01, ENTER2 = 2'b10, COMMIT = 2'b11} state_t;

  state_t               state, state_d;
  logic [CW-1:0]        cnt, cnt_d;
  logic [2*SEQ_LEN-1:0] shadow, shadow_d, code_d;
  logic                 match, match_d, upd_d, err_d;
  logic                 press, multi, timeout;
  logic [1:0]           sym;

  assign press = b1 | b2 | b3;
  assign multi = (b1 & b2) | (b1 & b3) | (b2 & b3);
  assign sym   = {b2 | b3, b1 | b3};

`ifdef SEQ_PROG_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] timer, timer_d;

  always_comb begin
    timer_d = '0;
    if ((state == ENTER1 || state == ENTER2) && !(press || check || prog))
      timer_d = timer + 1'b1;
  end

  assign timeout = (timer == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst)          timer <= '0;
    else if (timeout) timer <= '0;
    else              timer <= timer_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    shadow_d = shadow;
    match_d  = match;
    code_d   = code;
    upd_d    = 1'b0;
    err_d    = 1'b0;
    // COMMIT always lands the code; a prog arriving then still restarts entry.
    if (state == COMMIT) begin
      code_d  = shadow;
      upd_d   = 1'b1;
      state_d = IDLE;
    end
    if (prog) begin
      state_d  = ENTER1;
      cnt_d    = '0;
      shadow_d = '0;
    end else if (state == ENTER1 || state == ENTER2) begin
      if (multi || (press && check) || (press && cnt == LEN) || (check && cnt != LEN)) begin
        state_d = IDLE;
        err_d   = 1'b1;
      end else if (press) begin
        if (state == ENTER1) shadow_d[2*cnt +: 2] = sym;
        else if (sym != shadow[2*cnt +: 2]) match_d = 1'b0;
        cnt_d = cnt + 1'b1;
      end else if (check) begin
        cnt_d = '0;
        if (state == ENTER1) begin
          state_d = ENTER2;
          match_d = 1'b1;
        end else if (match) begin
          state_d = COMMIT;
        end else begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end else if (timeout) begin
        state_d = IDLE;
        err_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      shadow   <= '0;
      match    <= 1'b0;
      code     <= DEFAULT_CODE;
      code_upd <= 1'b0;
      error    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      shadow   <= shadow_d;
      match    <= match_d;
      code     <= code_d;
      code_upd <= upd_d;
      error    <= err_d;
      busy     <= (state_d != IDLE);
    end
  end

  assign state_check = state;

endmodule

// File: tb/tb_seq_programmer.sv
// tb/tb_seq_programmer.sv - directed and randomized checks of seq_programmer against a sequence-level model.
module tb_seq_programmer;
  localparam int LEN = 4;
  localparam int TMO = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b0, prog = 1'b0, b1 = 1'b0, b2 = 1'b0, b3 = 1'b0, check = 1'b0;
  logic [7:0] code;
  logic       code_upd, error, busy;
  logic [1:0] state_check;

  always #5 clk = ~clk;

  seq_programmer #(.SEQ_LEN(LEN), .DEFAULT_CODE(8'h1B), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .prog(prog), .b1(b1), .b2(b2), .b3(b3), .check(check),
    .code(code), .code_upd(code_upd), .error(error), .busy(busy), .state_check(state_check)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: phase 0 idle, 1 first entry, 2 second entry, 3 commit pending.
  int         m_phase;
  int         m_e1[$];
  int         m_e2[$];
  logic [7:0] m_code;
  logic       m_upd, m_err;

  function automatic logic [7:0] pack(input int q[$]);
    logic [7:0] r = '0;
    foreach (q[i]) r[2*i +: 2] = 2'(q[i]);
    return r;
  endfunction

  task automatic model_step(input logic p, x1, x2, x3, c);
    int n, s, sz;
    n  = int'(x1) + int'(x2) + int'(x3);
    s  = x1 ? 1 : (x2 ? 2 : 3);
    sz = (m_phase == 1) ? m_e1.size() : m_e2.size();
    m_upd = 1'b0;
    m_err = 1'b0;
    if (m_phase == 3) begin
      m_code = pack(m_e1);
      m_upd  = 1'b1;
      m_phase = 0;
    end
    if (p) begin
      m_phase = 1;
      m_e1.delete();
    end else if (m_phase == 1 || m_phase == 2) begin
      if (n > 1 || (n > 0 && c) || (n > 0 && sz == LEN) || (c && sz != LEN)) begin
        m_phase = 0;
        m_err = 1'b1;
      end else if (n == 1) begin
        if (m_phase == 1) m_e1.push_back(s);
        else m_e2.push_back(s);
      end else if (c) begin
        if (m_phase == 1) begin
          m_phase = 2;
          m_e2.delete();
        end else if (pack(m_e1) == pack(m_e2)) begin
          m_phase = 3;
        end else begin
          m_phase = 0;
          m_err = 1'b1;
        end
      end
    end
  endtask

  task automatic cyc(input logic p, x1, x2, x3, c);
    prog = p; b1 = x1; b2 = x2; b3 = x3; check = c;
    @(posedge clk);
    #1;
    prog = 0; b1 = 0; b2 = 0; b3 = 0; check = 0;
    model_step(p, x1, x2, x3, c);
  endtask

  task automatic btn(input int s);
    cyc(1'b0, s == 1, s == 2, s == 3, 1'b0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    m_phase = 0; m_e1.delete(); m_e2.delete();
    m_code = 8'h1B; m_upd = 1'b0; m_err = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(2);
    n_cmp++; if (code !== 8'h1B) begin n_bad++; $display("FAIL reset_code got %h want 1b", code); end
    n_cmp++; if (state_check !== 2'b00) begin n_bad++; $display("FAIL reset_state got %b want 00", state_check); end
    n_cmp++; if (busy !== 1'b0 || error !== 1'b0 || code_upd !== 1'b0) begin
      n_bad++; $display("FAIL reset_flags got busy=%b err=%b upd=%b want 0", busy, error, code_upd); end
  endtask

  task automatic test_program_ok();
    cyc(1, 0, 0, 0, 0);
    n_cmp++; if (state_check !== 2'b01 || busy !== 1'b1) begin n_bad++; $display("FAIL ok_enter1 got %b/%b want 01/1", state_check, busy); end
    btn(1); btn(2); btn(3); btn(1);
    cyc(0, 0, 0, 0, 1);
    n_cmp++; if (state_check !== 2'b10) begin n_bad++; $display("FAIL ok_enter2 got %b want 10", state_check); end
    btn(1); btn(2); btn(3); btn(1);
    cyc(0, 0, 0, 0, 1);
    n_cmp++; if (state_check !== 2'b11 || code !== 8'h1B || code_upd !== 1'b0) begin
      n_bad++; $display("FAIL ok_commit got st=%b code=%h upd=%b want 11/1b/0", state_check, code, code_upd); end
    cyc(0, 0, 0, 0, 0);
    n_cmp++; if (state_check !== 2'b00 || code !== 8'h79 || code_upd !== 1'b1 || busy !== 1'b0) begin
      n_bad++; $display("FAIL ok_update got st=%b code=%h upd=%b busy=%b want 00/79/1/0", state_check, code, code_upd, busy); end
    cyc(0, 0, 0, 0, 0);
    n_cmp++; if (code_upd !== 1'b0 || code !== 8'h79) begin n_bad++; $display("FAIL ok_upd_pulse got upd=%b code=%h want 0/79", code_upd, code); end
    do_reset(1);
  endtask

  task automatic test_mismatch();
    cyc(1, 0, 0, 0, 0);
    btn(1); btn(2); btn(3); btn(1);
    cyc(0, 0, 0, 0, 1);
    btn(1); btn(2); btn(3); btn(2);
    cyc(0, 0, 0, 0, 1);
    n_cmp++; if (error !== 1'b1 || state_check !== 2'b00 || code !== 8'h1B) begin
      n_bad++; $display("FAIL mismatch_abort got err=%b st=%b code=%h want 1/00/1b", error, state_check, code); end
    cyc(0, 0, 0, 0, 0);
    n_cmp++; if (error !== 1'b0 || code_upd !== 1'b0) begin n_bad++; $display("FAIL mismatch_pulse got err=%b upd=%b want 0/0", error, code_upd); end
  endtask

  task automatic test_short_simul();
    cyc(1, 0, 0, 0, 0);
    btn(1); btn(2);
    cyc(0, 0, 0, 0, 1);
    n_cmp++; if (error !== 1'b1 || state_check !== 2'b00 || code !== 8'h1B) begin
      n_bad++; $display("FAIL short_abort got err=%b st=%b code=%h want 1/00/1b", error, state_check, code); end
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0);
    n_cmp++; if (error !== 1'b1 || state_check !== 2'b00 || code !== 8'h1B) begin
      n_bad++; $display("FAIL simul_abort got err=%b st=%b code=%h want 1/00/1b", error, state_check, code); end
    cyc(1, 0, 0, 0, 0);
    btn(2); btn(2); btn(2); btn(2); btn(2);
    n_cmp++; if (error !== 1'b1 || state_check !== 2'b00) begin
      n_bad++; $display("FAIL overlong_abort got err=%b st=%b want 1/00", error, state_check); end
    cyc(1, 0, 0, 0, 0);
    btn(3);
    cyc(1, 0, 0, 0, 0);
    n_cmp++; if (error !== 1'b0 || state_check !== 2'b01) begin
      n_bad++; $display("FAIL prog_restart got err=%b st=%b want 0/01", error, state_check); end
    cyc(0, 0, 1, 0, 1);
    n_cmp++; if (error !== 1'b1 || state_check !== 2'b00) begin
      n_bad++; $display("FAIL btn_and_check got err=%b st=%b want 1/00", error, state_check); end
  endtask

  task automatic test_rst_mid();
    cyc(1, 0, 0, 0, 0);
    btn(3); btn(3); btn(1); btn(2);
    cyc(0, 0, 0, 0, 1);
    btn(3); btn(3); btn(1); btn(2);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    n_cmp++; if (code !== 8'h9F) begin n_bad++; $display("FAIL rst_pre_code got %h want 9f", code); end
    cyc(1, 0, 0, 0, 0);
    btn(1); btn(2);
    do_reset(1);
    n_cmp++; if (code !== 8'h1B || state_check !== 2'b00 || busy !== 1'b0 || error !== 1'b0 || code_upd !== 1'b0) begin
      n_bad++; $display("FAIL rst_mid got code=%h st=%b busy=%b err=%b upd=%b want 1b/00/0/0/0",
                        code, state_check, busy, error, code_upd); end
  endtask

  task automatic test_timeout();
    int err_at;
    err_at = -1;
    cyc(1, 0, 0, 0, 0);
    btn(1);
    for (int i = 0; i < TMO; i++) begin
      cyc(0, 0, 0, 0, 0);
      if (error === 1'b1 && err_at < 0) err_at = i + 1;
    end
`ifdef SEQ_PROG_TIMEOUT_EN
    n_cmp++; if (err_at != TMO || state_check !== 2'b00) begin
      n_bad++; $display("FAIL timeout got err_at=%0d st=%b want %0d/00", err_at, state_check, TMO); end
`else
    n_cmp++; if (err_at != -1 || state_check !== 2'b01) begin
      n_bad++; $display("FAIL no_timeout got err_at=%0d st=%b want -1/01", err_at, state_check); end
`endif
    do_reset(1);
  endtask

  function automatic logic [4:0] sv(input int s);
    return {1'b0, s == 1, s == 2, s == 3, 1'b0};
  endfunction

  task automatic test_random();
    logic [4:0] stim[$];
    int         code_syms[LEN];
    int         r;
    for (int round = 0; round < 60; round++) begin
      stim.delete();
      if ($urandom_range(0, 2) != 0) begin
        stim.push_back(5'b10000);
        for (int k = 0; k < LEN; k++) begin
          code_syms[k] = $urandom_range(1, 3);
          stim.push_back(sv(code_syms[k]));
        end
        stim.push_back(5'b00001);
        for (int k = 0; k < LEN; k++) begin
          r = $urandom_range(0, 99);
          if (r < 8) continue;
          stim.push_back(sv(r < 25 ? $urandom_range(1, 3) : code_syms[k]));
        end
        stim.push_back(5'b00001);
        stim.push_back(5'b00000);
        stim.push_back(5'b00000);
      end else begin
        for (int k = 0; k < 20; k++) begin
          r = $urandom_range(0, 99);
          if (r < 6) stim.push_back(5'b10000);
          else if (r < 45) stim.push_back(sv($urandom_range(1, 3)));
          else if (r < 58) stim.push_back(5'b00001);
          else if (r < 64) stim.push_back({1'b0, 3'(($urandom_range(3, 7) == 4) ? 3 : $urandom_range(3, 7)), $urandom_range(0, 1) == 1});
          else stim.push_back(5'b00000);
        end
      end
      foreach (stim[k]) begin
        cyc(stim[k][4], stim[k][3], stim[k][2], stim[k][1], stim[k][0]);
        n_cmp++; if (code !== m_code) begin n_bad++; $display("FAIL rand_code r=%0d k=%0d got %h want %h", round, k, code, m_code); end
        n_cmp++; if (code_upd !== m_upd) begin n_bad++; $display("FAIL rand_upd r=%0d k=%0d got %b want %b", round, k, code_upd, m_upd); end
        n_cmp++; if (error !== m_err) begin n_bad++; $display("FAIL rand_err r=%0d k=%0d got %b want %b", round, k, error, m_err); end
        n_cmp++; if (state_check !== 2'(m_phase)) begin n_bad++; $display("FAIL rand_state r=%0d k=%0d got %b want %0d", round, k, state_check, m_phase); end
        n_cmp++; if (busy !== (m_phase != 0)) begin n_bad++; $display("FAIL rand_busy r=%0d k=%0d got %b want %b", round, k, busy, m_phase != 0); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_program_ok();
    test_mismatch();
    test_short_simul();
    test_rst_mid();
    test_timeout();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
